// File: rtl/led_fader_pkg.sv
// Shared types and constants for the four-channel LED brightness fader.
package led_fader_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } fade_state_e;

  localparam int unsigned CHANNELS_DEF   = 32'd4;
  localparam int unsigned PWM_BITS_DEF   = 32'd8;
  // 14648 steps * 255 levels ~= 62 ms full ramp at 60 MHz
  localparam int unsigned STEP_DIV_60MHZ = 32'd14648;

  function automatic int unsigned pwm_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fader_if.sv
// Pattern-in / drive-out bundle between the counter stage and the fader.
interface led_fader_if
  import led_fader_pkg::*;
#(
  parameter int unsigned CHANNELS = CHANNELS_DEF
) ();

  logic [CHANNELS-1:0] in_bits;
  logic [CHANNELS-1:0] led;
  logic [CHANNELS-1:0] ramping;

  modport master (output in_bits, input led, input ramping);
  modport slave  (input in_bits, output led, output ramping);

endinterface

// File: rtl/led_fader_channel.sv
// One fader channel: target sampling, level ramp with saturation, PWM shadow and LED register.
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_bit_i,
  input  logic                step_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o,
  output logic                ramping_o
);

  localparam logic [PWM_BITS-1:0] MAX  = PWM_BITS'(pwm_max(PWM_BITS));
  localparam logic [PWM_BITS-1:0] ZERO = {PWM_BITS{1'b0}};
  localparam logic [PWM_BITS-1:0] ONE  = {{(PWM_BITS-1){1'b0}}, 1'b1};

  logic                in_q;
  logic [PWM_BITS-1:0] level_q;
  logic [PWM_BITS-1:0] level_d;
  logic [PWM_BITS-1:0] shadow_q;
  logic                led_q;
  logic                ramping_q;
  logic                ramping_d;
  fade_state_e         state_s;

  // classify the channel from the sampled target and current level
  always_comb begin
    if (in_q) begin
      if (level_q == MAX) state_s = ON;
      else                state_s = RISE;
    end else begin
      if (level_q == ZERO) state_s = OFF;
      else                 state_s = FALL;
    end
  end

  // move one unit toward the target on a step; ramping looks at the post-step level
  always_comb begin
    level_d = level_q;
    case (state_s)
      RISE: begin
        if (step_i) level_d = level_q + ONE;
        else        level_d = level_q;
      end
      FALL: begin
        if (step_i) level_d = level_q - ONE;
        else        level_d = level_q;
      end
      default: level_d = level_q;
    endcase
    if (in_q) ramping_d = (level_d != MAX);
    else      ramping_d = (level_d != ZERO);
  end

  // channel state; shadow only changes at the PWM period boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q      <= 1'b0;
      level_q   <= ZERO;
      shadow_q  <= ZERO;
      led_q     <= 1'b0;
      ramping_q <= 1'b0;
    end else begin
      in_q      <= in_bit_i;
      level_q   <= level_d;
      ramping_q <= ramping_d;
      if (pwm_cnt_i == MAX) shadow_q <= level_q;
      else                  shadow_q <= shadow_q;
      led_q     <= (shadow_q == MAX) | (shadow_q > pwm_cnt_i);
    end
  end

  assign led_o     = led_q;
  assign ramping_o = ramping_q;

endmodule

// File: rtl/led_fader.sv
// Fader top: shared step prescaler and PWM counter feeding CHANNELS independent channels.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int unsigned CHANNELS = CHANNELS_DEF,
  parameter int unsigned PWM_BITS = PWM_BITS_DEF,
  parameter int unsigned STEP_DIV = STEP_DIV_60MHZ
) (
  input  logic        clk,
  input  logic        rst_n,
  led_fader_if.slave  bus
);

  localparam int unsigned        PRE_W    = (STEP_DIV > 32'd1) ? $clog2(STEP_DIV) : 32'd1;
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(STEP_DIV - 32'd1);
  localparam logic [PRE_W-1:0]   PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
  localparam logic [PWM_BITS-1:0] PWM_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};

  logic [PRE_W-1:0]    prescaler_q;
  logic [PRE_W-1:0]    prescaler_d;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PWM_BITS-1:0] pwm_cnt_d;
  logic                step_s;
  logic [CHANNELS-1:0] led_s;
  logic [CHANNELS-1:0] ramping_s;

  // step strobe on the last prescaler count; PWM counter wraps naturally
  always_comb begin
    step_s = (prescaler_q == PRE_LAST);
    if (step_s) prescaler_d = {PRE_W{1'b0}};
    else        prescaler_d = prescaler_q + PRE_ONE;
    pwm_cnt_d = pwm_cnt_q + PWM_ONE;
  end

  // shared timebase registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= {PRE_W{1'b0}};
      pwm_cnt_q   <= {PWM_BITS{1'b0}};
    end else begin
      prescaler_q <= prescaler_d;
      pwm_cnt_q   <= pwm_cnt_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    led_fader_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_bit_i  (bus.in_bits[g]),
      .step_i    (step_s),
      .pwm_cnt_i (pwm_cnt_q),
      .led_o     (led_s[g]),
      .ramping_o (ramping_s[g])
    );
  end

  assign bus.led     = led_s;
  assign bus.ramping = ramping_s;

endmodule
